// File: rtl/seg_scan_sched_pkg.sv
`default_nettype none
//==============================================================================
// Module      : seg_pkg
// Description : Shared types and helpers for the 8-digit 7-segment scan
//               scheduler: digit record, scan FSM states and the wrap-around
//               next-enabled-digit search.
// Revision    : 1.0 - initial release
//==============================================================================
package seg_pkg;

    localparam int N_DIG = 8;

    // One display digit as stored in the register file and sent to the decoder
    typedef struct packed {
        logic       dot;
        logic [3:0] val;
    } digit_t;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Next set bit of mask strictly above cur, wrapping 7 -> 0.
    // Returns cur when cur is the only set bit or when mask is empty.
    function automatic logic [2:0] next_enabled(input logic [7:0] mask,
                                                 input logic [2:0] cur);
        logic [2:0] res;
        logic [2:0] cand;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cand = cur + 3'(i);
            if (!found && mask[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_sched_rr_arb2.sv
`default_nettype none
//==============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. Grant is combinational from the
//               requests; on a tie the requester that was not granted last
//               wins. last_grant updates on every grant.
// Revision    : 1.0 - initial release
//==============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0 = requester 0 (A) was granted last, 1 = requester 1 (B)
    logic       r_last;
    logic [1:0] w_gnt;

    // Pick a single winner; a tie goes to whoever did not win last time
    always_comb begin
        w_gnt = 2'b00;
        if (req == 2'b11) begin
            w_gnt = r_last ? 2'b01 : 2'b10;
        end else begin
            w_gnt = req;
        end
    end

    assign gnt = w_gnt;

    // Remember the most recent winner for the next tie-break
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_gnt[0]) begin
            r_last <= 1'b0;
        end else if (w_gnt[1]) begin
            r_last <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_sched.sv
`default_nettype none
//==============================================================================
// Module      : seg_scan_sched
// Description : Time-multiplexed scan scheduler for an 8-digit 7-segment
//               display. Holds the digit register file (write port shared by
//               two requesters via round-robin), and sequences chip-select and
//               digit code with a blank interval at the start of every slot.
//               Outputs update on the clock edge that closes the counter==0
//               and counter==BLANK_CYC cycles.
// Revision    : 1.0 - initial release
//==============================================================================
module seg_scan_sched #(
    parameter int F_CLK     = 50000000,
    parameter int F_SCAN    = 1000,
    parameter int BLANK_CYC = 500,
    parameter int N_DIG     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic [2:0] a_idx,
    input  logic [4:0] a_data,
    output logic       a_gnt,
    input  logic       b_req,
    input  logic [2:0] b_idx,
    input  logic [4:0] b_data,
    output logic       b_gnt,
    input  logic       mode,
    input  logic [2:0] sel_idx,
    input  logic [7:0] en_mask,
    output logic [7:0] cs,
    output logic [4:0] seg_code,
    output logic       frame_done
);

    import seg_pkg::*;

    localparam int              c_DIV       = F_CLK / F_SCAN;
    localparam int              c_CW        = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX   = c_CW'(c_DIV - 1);
    localparam logic [c_CW-1:0] c_CNT_BLANK = c_CW'(BLANK_CYC);

    logic [1:0]      w_gnt;
    logic [2:0]      w_next_ptr;

    digit_t          r_regfile [N_DIG];
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_ptr;
    scan_state_e     r_state;
    logic [7:0]      r_cs;
    digit_t          r_seg;
    logic            r_fd;
    // Set until the first pointer load after reset, so scanning starts at the
    // lowest enabled digit rather than stepping past digit 0.
    logic            r_first;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({b_req, a_req}),
        .gnt   (w_gnt)
    );

    assign a_gnt      = w_gnt[0];
    assign b_gnt      = w_gnt[1];
    assign cs         = r_cs;
    assign seg_code   = r_seg;
    assign frame_done = r_fd;

    // Searching from 7 makes the first pick the lowest enabled digit
    assign w_next_ptr = next_enabled(en_mask, r_first ? 3'd7 : r_ptr);

    // Register file: cleared by reset, written by the granted requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIG; i++) begin
                r_regfile[i] <= '0;
            end
        end else if (w_gnt[0]) begin
            r_regfile[a_idx] <= digit_t'(a_data);
        end else if (w_gnt[1]) begin
            r_regfile[b_idx] <= digit_t'(b_data);
        end
    end

    // Slot counter, scan FSM, digit pointer and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_ptr   <= 3'd0;
            r_state <= BLANK;
            r_cs    <= 8'hFF;
            r_seg   <= '0;
            r_fd    <= 1'b0;
            r_first <= 1'b1;
        end else begin
            r_fd  <= 1'b0;
            r_cnt <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + 1'b1;

            if (r_cnt == '0) begin
                // Slot start: blank the display and pick the next digit
                r_state <= BLANK;
                r_cs    <= 8'hFF;
                if (!mode) begin
                    r_ptr   <= sel_idx;
                    r_first <= 1'b0;
                end else if (en_mask != 8'h00) begin
                    r_ptr   <= w_next_ptr;
                    r_first <= 1'b0;
                    r_fd    <= !r_first && (w_next_ptr <= r_ptr);
                end
            end else if (r_cnt == c_CNT_BLANK) begin
                // End of blank: light the digit only if it is enabled
                if (r_state == BLANK && en_mask[r_ptr]) begin
                    r_state <= SHOW;
                    r_cs    <= ~(8'b1 << r_ptr);
                    r_seg   <= r_regfile[r_ptr];
                end
            end
        end
    end

endmodule
`default_nettype wire
